// File: rtl/controle_temporizador_5bits.sv
// controle_temporizador_5bits
// Programmable timer controller that sequences a WIDTH-bit counter.
// The host writes limit, direction and periodic mode through a valid/ready
// handshake. It then starts, pauses, resumes or stops the count.
// Ports:
//   clk           rising-edge clock
//   clear         asynchronous active-high reset
//   cfg_valid     host offers a configuration
//   cfg_ready     controller accepts a configuration (IDLE or DONE only)
//   cfg_limit     terminal value
//   cfg_down      1 = count limit..0, 0 = count 0..limit
//   cfg_periodic  1 = reload at terminal and keep running, 0 = stop at terminal
//   start         begin (IDLE/DONE) or resume (PAUSED)
//   pause         freeze the count while running
//   stop          abort to IDLE
//   count         registered counter value
//   state         IDLE=00, RUN=01, PAUSED=10, DONE=11
//   running       high while in RUN
//   done          registered one-cycle pulse on terminal count
module controle_temporizador_5bits #(
  parameter int WIDTH         = 5,
  parameter int DEFAULT_LIMIT = 31
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_down,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             running,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PAUSED = 2'b10,
    DONE   = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] LIMIT_RST = WIDTH'(DEFAULT_LIMIT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             down_q, down_d;
  logic             periodic_q, periodic_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] init_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] new_init;
  logic             cfg_xfer;

  // The start and terminal values both depend on the latched direction.
  // new_init is the start value that a configuration accepted this cycle
  // would produce.
  assign init_val = down_q ? limit_q : '0;
  assign term_val = down_q ? '0 : limit_q;
  assign new_init = cfg_down ? cfg_limit : '0;

  assign cfg_ready = (state_q == IDLE) || (state_q == DONE);
  assign cfg_xfer  = cfg_valid && cfg_ready;

  assign count   = count_q;
  assign state   = state_q;
  assign running = (state_q == RUN);
  assign done    = done_q;

  // Next-state logic. A configuration transfer has priority over every
  // command in IDLE/DONE, so a start in the same cycle is dropped. In RUN
  // the terminal check comes before the step, so the counter never wraps.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    limit_d    = limit_q;
    down_d     = down_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;

    if (cfg_xfer) begin
      limit_d    = cfg_limit;
      down_d     = cfg_down;
      periodic_d = cfg_periodic;
      count_d    = new_init;
      state_d    = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            count_d = init_val;
            state_d = RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
            count_d = init_val;
          end else if (pause) begin
            state_d = PAUSED;
          end else if (count_q == term_val) begin
            done_d = 1'b1;
            if (periodic_q) begin
              count_d = init_val;
            end else begin
              state_d = DONE;
            end
          end else if (down_q) begin
            count_d = count_q - 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
        PAUSED: begin
          if (stop) begin
            state_d = IDLE;
            count_d = init_val;
          end else if (start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (stop) begin
            state_d = IDLE;
            count_d = init_val;
          end else if (start) begin
            state_d = RUN;
            count_d = init_val;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  // State registers. clear acts immediately, even in the middle of a count.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      count_q    <= '0;
      limit_q    <= LIMIT_RST;
      down_q     <= 1'b0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      limit_q    <= limit_d;
      down_q     <= down_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
    end
  end

endmodule
